// File: rtl/conv_coef_ctrl_pkg.sv
// Shared constants and types for the convolution coefficient controller.
// Holds the kernel geometry, the register map, the FSM encoding and the identity kernel.
package conv_coef_ctrl_pkg;

  localparam int unsigned NTAP       = 25;
  localparam int unsigned CW         = 8;
  localparam int unsigned SW         = 4;
  localparam int unsigned AW         = 5;
  localparam int unsigned CNTW       = 8;
  localparam int unsigned KW         = NTAP * CW;
  localparam int unsigned ADDR_SHIFT = 25;
  localparam int unsigned CENTRE_TAP = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  // Pass-through kernel: centre tap = 1, all other taps 0.
  localparam logic [KW-1:0] IDENTITY_KERNEL = KW'(1) << (CENTRE_TAP * CW);

endpackage

// File: rtl/conv_coef_ctrl_edge.sv
// Frame-edge detector: remembers the previous rx_vs activity and pulses
// for one cycle on the transition into the active level.
module conv_coef_ctrl_edge #(
  parameter bit VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_vs,
  output logic vs_edge_c
);

  logic vs_act_c;
  logic vs_hist;

  assign vs_act_c = (rx_vs == VS_POL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vs_hist <= 1'b0;
    else     vs_hist <= vs_act_c;
  end

  assign vs_edge_c = vs_act_c & ~vs_hist;

endmodule

// File: rtl/conv_coef_ctrl.sv
// Double-banked 5x5 kernel store: register writes land in the shadow bank,
// which is copied to the active bank only on a frame edge after a commit.
module conv_coef_ctrl
  import conv_coef_ctrl_pkg::*;
#(
  parameter bit VS_POL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_vs,
  input  logic            cfg_wr,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [CW-1:0]   cfg_data,
  input  logic            cfg_commit,
  output logic            cfg_ready,
  output logic            cfg_err,
  output logic            cfg_pending,
  output logic [KW-1:0]   coef_active,
  output logic [SW-1:0]   shift_active,
  output logic [CNTW-1:0] commit_cnt
);

  state_t          state, state_nxt;
  logic            vs_edge_c;
  logic            wr_coef_c, wr_shift_c, wr_bad_c, do_swap_c;
  logic [KW-1:0]   shadow;
  logic [SW-1:0]   shadow_shift;

  conv_coef_ctrl_edge #(.VS_POL(VS_POL)) u_edge (
    .clk       (clk),
    .rst       (rst),
    .rx_vs     (rx_vs),
    .vs_edge_c (vs_edge_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Writes are only decoded in IDLE; a frame edge in IDLE is deliberately ignored.
  always_comb begin
    state_nxt  = state;
    wr_coef_c  = 1'b0;
    wr_shift_c = 1'b0;
    wr_bad_c   = 1'b0;
    do_swap_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_wr) begin
          if (cfg_addr < AW'(ADDR_SHIFT))       wr_coef_c  = 1'b1;
          else if (cfg_addr == AW'(ADDR_SHIFT)) wr_shift_c = 1'b1;
          else                                  wr_bad_c   = 1'b1;
        end
        if (cfg_commit) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (vs_edge_c) state_nxt = ST_SWAP;
      end
      ST_SWAP: begin
        do_swap_c = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status flags track the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready   <= 1'b1;
      cfg_pending <= 1'b0;
    end else begin
      cfg_ready   <= (state_nxt == ST_IDLE);
      cfg_pending <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow       <= IDENTITY_KERNEL;
      shadow_shift <= '0;
    end else begin
      for (int i = 0; i < NTAP; i++) begin
        if (wr_coef_c && (cfg_addr == AW'(i))) shadow[i*CW +: CW] <= cfg_data;
      end
      if (wr_shift_c) shadow_shift <= cfg_data[SW-1:0];
    end
  end

  // Active bank and commit bookkeeping change together in the single SWAP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_active  <= IDENTITY_KERNEL;
      shift_active <= '0;
      commit_cnt   <= '0;
      cfg_err      <= 1'b0;
    end else if (do_swap_c) begin
      coef_active  <= shadow;
      shift_active <= shadow_shift;
      commit_cnt   <= commit_cnt + CNTW'(1);
      cfg_err      <= 1'b0;
    end else if (wr_bad_c) begin
      cfg_err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_coef_ctrl.sv
// Bench for conv_coef_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the two banks.
module tb_conv_coef_ctrl;
  import conv_coef_ctrl_pkg::*;

  logic            clk;
  logic            rst;
  logic            rx_vs;
  logic            cfg_wr;
  logic [AW-1:0]   cfg_addr;
  logic [CW-1:0]   cfg_data;
  logic            cfg_commit;
  logic            cfg_ready;
  logic            cfg_err;
  logic            cfg_pending;
  logic [KW-1:0]   coef_active;
  logic [SW-1:0]   shift_active;
  logic [CNTW-1:0] commit_cnt;

  int errors = 0;
  int checks = 0;

  // Model: kernel images as tap arrays plus a few flags describing the commit.
  logic [7:0] m_shadow [NTAP];
  logic [7:0] m_active [NTAP];
  logic [3:0] m_sh_shift, m_act_shift;
  logic       m_err;
  int         m_cnt;
  bit         m_waiting_frame, m_swap_next, m_prev_vs;
  logic [KW-1:0] ident;

  conv_coef_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rx_vs        (rx_vs),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_commit   (cfg_commit),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .cfg_pending  (cfg_pending),
    .coef_active  (coef_active),
    .shift_active (shift_active),
    .commit_cnt   (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] pack_active();
    logic [KW-1:0] v = '0;
    for (int i = 0; i < NTAP; i++) v[i*8 +: 8] = m_active[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NTAP; i++) begin
      m_shadow[i] = (i == 12) ? 8'd1 : 8'd0;
      m_active[i] = (i == 12) ? 8'd1 : 8'd0;
    end
    m_sh_shift = 0; m_act_shift = 0; m_err = 0; m_cnt = 0;
    m_waiting_frame = 0; m_swap_next = 0; m_prev_vs = 0;
  endtask

  // One clock edge worth of behaviour, using the inputs present at that edge.
  task automatic model_step();
    bit frame_start;
    if (rst) begin
      model_reset();
      return;
    end
    frame_start = rx_vs && !m_prev_vs;
    m_prev_vs = rx_vs;
    if (m_swap_next) begin
      m_active = m_shadow;
      m_act_shift = m_sh_shift;
      m_cnt = (m_cnt + 1) % 256;
      m_err = 0;
      m_swap_next = 0;
    end else if (m_waiting_frame) begin
      if (frame_start) begin
        m_waiting_frame = 0;
        m_swap_next = 1;
      end
    end else begin
      if (cfg_wr) begin
        if (cfg_addr < 25)       m_shadow[cfg_addr] = cfg_data;
        else if (cfg_addr == 25) m_sh_shift = cfg_data[3:0];
        else                     m_err = 1;
      end
      if (cfg_commit) m_waiting_frame = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    bit busy = m_waiting_frame || m_swap_next;
    chk({tag, "_coef"},    coef_active,            pack_active());
    chk({tag, "_shift"},   KW'(shift_active),      KW'(m_act_shift));
    chk({tag, "_ready"},   KW'(cfg_ready),         KW'(!busy));
    chk({tag, "_pending"}, KW'(cfg_pending),       KW'(busy));
    chk({tag, "_err"},     KW'(cfg_err),           KW'(m_err));
    chk({tag, "_cnt"},     KW'(commit_cnt),        KW'(m_cnt));
  endtask

  task automatic tick(input string tag = "cyc");
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic wr(input int addr, input int data);
    cfg_wr = 1'b1; cfg_addr = AW'(addr); cfg_data = CW'(data);
    tick("wr");
    cfg_wr = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick("commit");
    cfg_commit = 1'b0;
  endtask

  task automatic vs_pulse();
    rx_vs = 1'b1; tick("vs_hi");
    rx_vs = 1'b0; tick("vs_lo");
  endtask

  initial begin
    ident = '0;
    ident[12*8] = 1'b1;
    rst = 1'b1; rx_vs = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    model_reset();
    tick("rst"); tick("rst");
    rst = 1'b0;

    // 1: idle after reset
    repeat (100) tick("idle");
    chk("t1_coef", coef_active, ident);
    chk("t1_shift", KW'(shift_active), KW'(0));
    chk("t1_ready", KW'(cfg_ready), KW'(1));
    chk("t1_cnt", KW'(commit_cnt), KW'(0));

    // 2: basic commit and swap latency
    wr(0, 8'hFD); wr(12, 8); wr(25, 3);
    commit();
    rx_vs = 1'b1; tick("t2_edge");
    chk("t2_hold_tap12", KW'(coef_active[12*8 +: 8]), KW'(1));
    chk("t2_hold_pending", KW'(cfg_pending), KW'(1));
    rx_vs = 1'b0; tick("t2_swap");
    chk("t2_tap0", KW'(coef_active[0 +: 8]), KW'(8'hFD));
    chk("t2_tap12", KW'(coef_active[12*8 +: 8]), KW'(8));
    chk("t2_shift", KW'(shift_active), KW'(3));
    chk("t2_cnt", KW'(commit_cnt), KW'(1));
    chk("t2_pending", KW'(cfg_pending), KW'(0));

    // 3: edge coinciding with commit does not count; held vs keeps ARMED
    wr(1, 8'h11);
    cfg_commit = 1'b1; rx_vs = 1'b1; tick("t3_same");
    cfg_commit = 1'b0;
    repeat (5) tick("t3_held");
    chk("t3_pending", KW'(cfg_pending), KW'(1));
    chk("t3_cnt", KW'(commit_cnt), KW'(1));
    chk("t3_tap1_old", KW'(coef_active[1*8 +: 8]), KW'(0));
    rx_vs = 1'b0; tick("t3_low");
    vs_pulse();
    chk("t3_cnt2", KW'(commit_cnt), KW'(2));
    chk("t3_tap1", KW'(coef_active[1*8 +: 8]), KW'(8'h11));

    // 4: writes and commits while ARMED are ignored
    commit();
    cfg_wr = 1'b1; cfg_addr = AW'(5); cfg_data = 8'h7F; cfg_commit = 1'b1;
    tick("t4_armed_wr");
    cfg_wr = 1'b0; cfg_commit = 1'b0;
    chk("t4_err", KW'(cfg_err), KW'(0));
    vs_pulse();
    chk("t4_tap5", KW'(coef_active[5*8 +: 8]), KW'(0));
    chk("t4_cnt", KW'(commit_cnt), KW'(3));

    // 5: invalid address sets sticky error, swap clears it
    wr(30, 8'h55);
    chk("t5_err", KW'(cfg_err), KW'(1));
    commit();
    vs_pulse();
    chk("t5_err_clr", KW'(cfg_err), KW'(0));
    chk("t5_cnt", KW'(commit_cnt), KW'(4));

    // 6: asynchronous reset while ARMED discards the commit
    wr(7, 8'h42);
    commit();
    #3 rst = 1'b1;
    #1;
    model_reset();
    compare_all("t6_async");
    chk("t6_ready", KW'(cfg_ready), KW'(1));
    tick("t6_rst");
    rst = 1'b0;
    vs_pulse();
    tick("t6_after");
    chk("t6_coef", coef_active, ident);
    chk("t6_cnt", KW'(commit_cnt), KW'(0));
    chk("t6_pending", KW'(cfg_pending), KW'(0));

    // 256 commits wrap the counter back to zero
    for (int n = 0; n < 256; n++) begin
      commit();
      vs_pulse();
    end
    chk("t6_wrap", KW'(commit_cnt), KW'(0));

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      cfg_wr     = ($urandom_range(0, 1) == 1);
      cfg_addr   = AW'($urandom_range(0, 31));
      cfg_data   = CW'($urandom);
      cfg_commit = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) rx_vs = ~rx_vs;
      tick("rand");
    end
    cfg_wr = 1'b0; cfg_commit = 1'b0; rx_vs = 1'b0;
    repeat (4) tick("drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
